// File: rtl/tile_buffer_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tile_pkg : shared types and defaults for the tile buffer scheduler          |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
package tile_pkg;

  localparam int PIXW            = 72;
  localparam int POS_ADDRW_DEF   = 8;
  localparam int TILE_WIDTH_DEF  = 128;
  localparam int TILE_HEIGHT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RASTER     = 3'd1,
    ST_RESOLVE    = 3'd2,
    ST_CLEAR_REQ  = 3'd3,
    ST_CLEAR_WAIT = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [4*PIXW-1:0]        data;
    logic [POS_ADDRW_DEF-1:0] x;
    logic [POS_ADDRW_DEF-1:0] y;
  } px_quad_t;

endpackage
`default_nettype wire

// File: rtl/tile_buffer_sched_resolve_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | resolve_skid_fifo : 2-entry valid/ready FIFO carrying resolved quads        |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
module resolve_skid_fifo #(
  parameter type ENTRY_T = tile_pkg::px_quad_t
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_push,
  input  ENTRY_T     i_data,
  output logic       o_valid,
  input  logic       i_ready,
  output ENTRY_T     o_data,
  output logic [1:0] o_count
);

  ENTRY_T     mem_q [2];
  ENTRY_T     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       w_pop, w_push_ok;

  always_comb begin
    o_valid   = (count_q != 2'd0);
    o_data    = mem_q[rd_ptr_q];
    o_count   = count_q;
    w_pop     = o_valid && i_ready;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    w_push_ok = i_push && ((count_q != 2'd2) || w_pop);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (w_push_ok) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, w_push_ok} - {1'b0, w_pop};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_buffer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tile_buffer_sched : RASTER -> RESOLVE -> CLEAR lifecycle of a tile buffer   |
// | Optional macro TILE_SCHED_PERF_CNT_EN adds per-tile cycle counters.         |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
module tile_buffer_sched #(
  parameter int POS_ADDRW   = tile_pkg::POS_ADDRW_DEF,
  parameter int TILE_WIDTH  = tile_pkg::TILE_WIDTH_DEF,
  parameter int TILE_HEIGHT = tile_pkg::TILE_HEIGHT_DEF,
  parameter int PIXW        = tile_pkg::PIXW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_tile_start,
  input  logic                 i_tile_done,
  output logic                 o_idle,
  input  logic [POS_ADDRW-1:0] i_wr_x,
  input  logic [POS_ADDRW-1:0] i_wr_y,
  input  logic [4*PIXW-1:0]    i_wr_data,
  input  logic [3:0]           i_wr_mask,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic                 i_tb_ready,
  output logic [POS_ADDRW-1:0] o_tb_write_x,
  output logic [POS_ADDRW-1:0] o_tb_write_y,
  output logic [4*PIXW-1:0]    o_tb_pixel_data,
  output logic [3:0]           o_tb_write_mask,
  output logic                 o_tb_write_valid,
  output logic [POS_ADDRW-1:0] o_tb_read_x,
  output logic [POS_ADDRW-1:0] o_tb_read_y,
  output logic                 o_tb_read_valid,
  input  logic [4*PIXW-1:0]    i_tb_read_data,
  input  logic                 i_tb_read_valid,
  output logic                 o_tb_clear,
  input  logic                 i_tb_clear_done,
  input  logic [47:0]          i_clear_color,
  input  logic [23:0]          i_clear_depth,
  output logic [47:0]          o_tb_clear_color,
  output logic [23:0]          o_tb_clear_depth,
  output logic [4*PIXW-1:0]    o_px_data,
  output logic [POS_ADDRW-1:0] o_px_x,
  output logic [POS_ADDRW-1:0] o_px_y,
  output logic                 o_px_valid,
  input  logic                 i_px_ready,
  output logic                 o_px_last
`ifdef TILE_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]          o_perf_raster_cycles,
  output logic [31:0]          o_perf_resolve_cycles,
  output logic [31:0]          o_perf_stall_cycles
`endif
);

  import tile_pkg::*;

  typedef struct packed {
    logic [4*PIXW-1:0]    data;
    logic [POS_ADDRW-1:0] x;
    logic [POS_ADDRW-1:0] y;
  } quad_t;

  localparam logic [POS_ADDRW-1:0] c_x_last = POS_ADDRW'(TILE_WIDTH - 2);
  localparam logic [POS_ADDRW-1:0] c_y_last = POS_ADDRW'(TILE_HEIGHT - 2);
  localparam logic [POS_ADDRW-1:0] c_step   = POS_ADDRW'(2);

  sched_state_t         state_q, state_d;
  logic [POS_ADDRW-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic [POS_ADDRW-1:0] tag_x_q, tag_x_d, tag_y_q, tag_y_d;
  logic                 scan_done_q, scan_done_d;
  logic                 inflight_q, inflight_d;

  logic                 w_in_raster, w_in_resolve;
  logic                 w_issue, w_return, w_pop, w_last;
  logic [2:0]           w_occ;
  logic                 w_fifo_valid;
  logic [1:0]           w_fifo_count;
  quad_t                w_push_entry, w_head;

  resolve_skid_fifo #(
    .ENTRY_T (quad_t)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_return),
    .i_data  (w_push_entry),
    .o_valid (w_fifo_valid),
    .i_ready (i_px_ready),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_in_raster  = (state_q == ST_RASTER);
    w_in_resolve = (state_q == ST_RESOLVE);

    o_idle           = (state_q == ST_IDLE) && i_tb_ready;
    o_wr_ready       = w_in_raster && i_wr_valid && i_tb_ready;
    o_tb_write_valid = o_wr_ready;
    o_tb_write_x     = w_in_raster ? i_wr_x    : '0;
    o_tb_write_y     = w_in_raster ? i_wr_y    : '0;
    o_tb_pixel_data  = w_in_raster ? i_wr_data : '0;
    o_tb_write_mask  = w_in_raster ? i_wr_mask : '0;

    w_pop  = w_fifo_valid && i_px_ready;
    w_last = w_fifo_valid && (w_head.x == c_x_last) && (w_head.y == c_y_last);
    // Occupancy counted after this cycle's pop keeps the stream at one quad per cycle.
    w_occ   = {1'b0, w_fifo_count} - {2'b00, w_pop} + {2'b00, inflight_q};
    w_issue = w_in_resolve && !scan_done_q && (w_occ < 3'd2);
    w_return = w_in_resolve && inflight_q && i_tb_read_valid;

    w_push_entry.data = i_tb_read_data;
    w_push_entry.x    = tag_x_q;
    w_push_entry.y    = tag_y_q;

    o_tb_read_valid = w_issue;
    o_tb_read_x     = rd_x_q;
    o_tb_read_y     = rd_y_q;

    o_px_valid = w_fifo_valid;
    o_px_data  = w_fifo_valid ? w_head.data : '0;
    o_px_x     = w_fifo_valid ? w_head.x    : '0;
    o_px_y     = w_fifo_valid ? w_head.y    : '0;
    o_px_last  = w_last;

    o_tb_clear       = (state_q == ST_CLEAR_REQ);
    o_tb_clear_color = o_tb_clear ? i_clear_color : '0;
    o_tb_clear_depth = o_tb_clear ? i_clear_depth : '0;

    rd_x_d      = rd_x_q;
    rd_y_d      = rd_y_q;
    tag_x_d     = tag_x_q;
    tag_y_d     = tag_y_q;
    scan_done_d = scan_done_q;
    inflight_d  = inflight_q;

    if (w_return) begin
      inflight_d = 1'b0;
    end
    if (w_issue) begin
      inflight_d = 1'b1;
      tag_x_d    = rd_x_q;
      tag_y_d    = rd_y_q;
      if (rd_x_q == c_x_last) begin
        rd_x_d = '0;
        if (rd_y_q == c_y_last) begin
          rd_y_d      = '0;
          scan_done_d = 1'b1;
        end else begin
          rd_y_d = rd_y_q + c_step;
        end
      end else begin
        rd_x_d = rd_x_q + c_step;
      end
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (i_tile_start && i_tb_ready) state_d = ST_RASTER;
      ST_RASTER:     if (i_tile_done) state_d = ST_RESOLVE;
      ST_RESOLVE: begin
        if (w_pop && w_last) begin
          state_d     = ST_CLEAR_REQ;
          scan_done_d = 1'b0;
          inflight_d  = 1'b0;
        end
      end
      ST_CLEAR_REQ:  state_d = ST_CLEAR_WAIT;
      ST_CLEAR_WAIT: if (i_tb_clear_done) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      tag_x_q     <= '0;
      tag_y_q     <= '0;
      scan_done_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      tag_x_q     <= tag_x_d;
      tag_y_q     <= tag_y_d;
      scan_done_q <= scan_done_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef TILE_SCHED_PERF_CNT_EN
  logic [31:0] perf_raster_q, perf_raster_d;
  logic [31:0] perf_resolve_q, perf_resolve_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        w_tile_begin;

  always_comb begin
    w_tile_begin   = (state_q == ST_IDLE) && (state_d == ST_RASTER);
    perf_raster_d  = perf_raster_q;
    perf_resolve_d = perf_resolve_q;
    perf_stall_d   = perf_stall_q;
    if (w_tile_begin) begin
      perf_raster_d  = '0;
      perf_resolve_d = '0;
      perf_stall_d   = '0;
    end else begin
      if (w_in_raster && (perf_raster_q != '1))
        perf_raster_d = perf_raster_q + 32'd1;
      if (w_in_resolve && (perf_resolve_q != '1))
        perf_resolve_d = perf_resolve_q + 32'd1;
      if (w_in_resolve && w_fifo_valid && !i_px_ready && (perf_stall_q != '1))
        perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_raster_q  <= '0;
      perf_resolve_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_raster_q  <= perf_raster_d;
      perf_resolve_q <= perf_resolve_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign o_perf_raster_cycles  = perf_raster_q;
  assign o_perf_resolve_cycles = perf_resolve_q;
  assign o_perf_stall_cycles   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/tile_buffer_sched.md
Name: tile_buffer_sched

Overview:
- Sequences one tile buffer through its per-tile lifecycle: RASTER, then RESOLVE, then CLEAR.
- RASTER: forwards 2x2 write quads from the raster backend.
- RESOLVE: scans the whole tile as 2x2 read quads and streams them downstream with valid/ready backpressure.
- CLEAR: issues the buffer clear and waits for completion before accepting the next tile.
- Sits between the raster backend, the tile buffer and the AXI writeback stage.

Parameters:
- POS_ADDRW, 8, tile-local x/y coordinate width.
- TILE_WIDTH, 128, tile width in pixels; even, at most 2^POS_ADDRW.
- TILE_HEIGHT, 64, tile height in pixels; even, at most 2^POS_ADDRW.
- PIXW, 72, pixel word width (48-bit color + 24-bit depth).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_tile_start  in  1  raster begins a new tile (accepted only in IDLE)
- i_tile_done  in  1  raster has finished the current tile (accepted only in RASTER)
- o_idle  out  1  scheduler is in IDLE and the tile buffer is ready
- i_wr_x, i_wr_y  in  POS_ADDRW  quad origin (even coordinates)
- i_wr_data  in  PIXW x4  quad pixels
- i_wr_mask  in  4  per-pixel write enable
- i_wr_valid  in  1  raster quad valid
- o_wr_ready  out  1  quad accepted this cycle
- i_tb_ready  in  1  tile buffer ready
- o_tb_write_x, o_tb_write_y  out  POS_ADDRW  write quad origin to buffer
- o_tb_pixel_data  out  PIXW x4  write pixels to buffer
- o_tb_write_mask  out  4  write mask to buffer
- o_tb_write_valid  out  1  write strobe to buffer
- o_tb_read_x, o_tb_read_y  out  POS_ADDRW  read quad origin to buffer
- o_tb_read_valid  out  1  read strobe to buffer
- i_tb_read_data  in  PIXW x4  buffer read data (1-cycle latency)
- i_tb_read_valid  in  1  buffer read data valid
- o_tb_clear  out  1  clear pulse to buffer
- i_tb_clear_done  in  1  buffer clear complete
- i_clear_color  in  48  clear color
- i_clear_depth  in  24  clear depth
- o_tb_clear_color  out  48  color sent with the clear
- o_tb_clear_depth  out  24  depth sent with the clear
- o_px_data  out  PIXW x4  resolved quad
- o_px_x, o_px_y  out  POS_ADDRW  resolved quad origin
- o_px_valid  out  1  resolved quad valid
- i_px_ready  in  1  downstream ready
- o_px_last  out  1  final quad of the tile

Behaviour:
- States: IDLE, RASTER, RESOLVE, CLEAR_REQ, CLEAR_WAIT.
- Reset: state=IDLE. All o_tb_* strobes, o_px_valid, o_px_last, o_wr_ready are 0; coordinates and data are 0. o_idle = (state==IDLE) && i_tb_ready, so it stays low while the buffer performs its post-reset self-clear.
- A reset asserted mid-tile abandons the tile and discards the skid contents. No clear is issued; the buffer's own reset clears it.
- IDLE -> RASTER: on i_tile_start && i_tb_ready. i_tile_start is ignored outside IDLE.
- RASTER, write path is combinational:
  - o_wr_ready = o_tb_write_valid = i_wr_valid && i_tb_ready.
  - Coordinates, data and mask pass straight through.
  - The scheduler does not check quad parity.
- RASTER -> RESOLVE: on i_tile_done. A write presented in the same cycle is still accepted; o_wr_ready is 0 from the next cycle onward.
- RESOLVE scan:
  - Read origin starts at (0,0); x steps by 2 to TILE_WIDTH-2, then x wraps to 0 and y steps by 2. Total (TILE_WIDTH/2)*(TILE_HEIGHT/2) reads.
  - A read is issued only when (skid occupancy + in-flight reads) < 2. In-flight reads number 0 or 1, so the rate is one quad per cycle when downstream is always ready.
- Return path:
  - Returning data, tagged with its origin, enters a 2-entry FIFO that drives o_px_*.
  - o_px_* are held stable while o_px_valid && !i_px_ready.
  - o_px_last is asserted with quad (TILE_WIDTH-2, TILE_HEIGHT-2).
- RESOLVE -> CLEAR_REQ: on the cycle the last quad handshakes downstream.
- CLEAR_REQ: o_tb_clear=1 for exactly one cycle, with i_clear_color/i_clear_depth sampled that cycle and driven on o_tb_clear_color/o_tb_clear_depth; then go to CLEAR_WAIT.
- CLEAR_WAIT -> IDLE: on i_tb_clear_done.
- Read strobes are never asserted outside RESOLVE. Write strobes are never asserted outside RASTER.

Optional Feature:
- Macro TILE_SCHED_PERF_CNT_EN.
- Enabled: adds outputs o_perf_raster_cycles, o_perf_resolve_cycles, o_perf_stall_cycles (32 bit each).
  - Raster and resolve counters count cycles spent in RASTER and RESOLVE for the current tile. They clear on IDLE->RASTER and saturate at 2^32-1.
  - The stall counter counts RESOLVE cycles with o_px_valid && !i_px_ready.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package tile_pkg holds: state enum sched_state_t, PIXW, default tile dimensions, and typedef px_quad_t (4 x PIXW plus x/y origin).
- Sub-module resolve_skid_fifo: 2-entry valid/ready FIFO of px_quad_t, exposing its occupancy count.

Test Plan:
- Reset, i_tb_ready held low 10 cycles -> o_idle=0 throughout. Raise i_tb_ready -> o_idle=1 next cycle; all strobes stay 0.
- Tile start, 3 quads written at (0,0),(2,0),(0,2) with mask 4'hF, i_tile_done coincident with the 3rd quad -> all 3 reach the buffer, and o_wr_ready=0 afterwards.
- Resolve with i_px_ready=1 and a 1-cycle buffer model -> 2048 quads in raster order, one per cycle after the first. o_px_last only on (126,62).
- Resolve with i_px_ready toggling 1-of-3 cycles -> no quad lost or duplicated, o_px_* stable while stalled, at most 1 read in flight.
- After the last quad with i_clear_color=48'h123456789ABC and i_clear_depth=24'hFFFFFF -> single-cycle o_tb_clear carrying those values. i_tb_clear_done after 2048 cycles -> IDLE.
- rstn asserted mid-RESOLVE -> outputs go to 0 immediately. After release, a new tile starts from (0,0).
